// File: rtl/e203_ifu_pfq_if.sv
// Signal bundle for the IFU prefetch queue: ICB fetch port, instruction output,
// flush/halt handshakes and debug occupancy. "master" is the queue's view.
interface e203_ifu_pfq_if #(
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32,
    parameter int PF_DEPTH   = 4,
    parameter int CNT_W      = $clog2(PF_DEPTH + 1)
);
    logic [PC_SIZE-1:0]    pc_rtvec;
    logic                  icb_cmd_valid;
    logic                  icb_cmd_ready;
    logic [PC_SIZE-1:0]    icb_cmd_addr;
    logic                  icb_rsp_valid;
    logic                  icb_rsp_ready;
    logic                  icb_rsp_err;
    logic [INSTR_SIZE-1:0] icb_rsp_rdata;
    logic                  o_valid;
    logic                  o_ready;
    logic [INSTR_SIZE-1:0] o_instr;
    logic [PC_SIZE-1:0]    o_pc;
    logic                  o_err;
    logic                  flush_req;
    logic [PC_SIZE-1:0]    flush_pc;
    logic                  flush_ack;
    logic                  halt_req;
    logic                  halt_ack;
    logic [CNT_W-1:0]      occupancy;

    modport master (
        input  pc_rtvec, icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
               o_ready, flush_req, flush_pc, halt_req,
        output icb_cmd_valid, icb_cmd_addr, icb_rsp_ready, o_valid, o_instr, o_pc,
               o_err, flush_ack, halt_ack, occupancy
    );

    modport slave (
        output pc_rtvec, icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
               o_ready, flush_req, flush_pc, halt_req,
        input  icb_cmd_valid, icb_cmd_addr, icb_rsp_ready, o_valid, o_instr, o_pc,
               o_err, flush_ack, halt_ack, occupancy
    );
endinterface

// File: rtl/e203_ifu_pfq.sv
// IFU instruction prefetch queue with flush drop-counting and halt handshake.
// Optional same-cycle response bypass enabled by defining E203_IFU_PFQ_BYPASS_EN.
module e203_ifu_pfq #(
    parameter int PC_SIZE    = 32,
    parameter int INSTR_SIZE = 32,
    parameter int PF_DEPTH   = 4,
    parameter int CNT_W      = $clog2(PF_DEPTH + 1)
) (
    input logic              clk,
    input logic              rst,
    e203_ifu_pfq_if.master   io
);
    localparam int             PTR_W     = $clog2(PF_DEPTH);
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(PF_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(PF_DEPTH);
    localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(4);

    logic [PC_SIZE-1:0]    r_fetchPc;
    logic [PC_SIZE-1:0]    r_outPc;
    logic                  r_cmdPending;
    logic [CNT_W-1:0]      r_outsCnt;
    logic [CNT_W-1:0]      r_dropCnt;
    logic [CNT_W-1:0]      r_occ;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [INSTR_SIZE-1:0] r_instrMem [PF_DEPTH];
    logic                  r_errMem   [PF_DEPTH];

    logic                  w_credit;
    logic                  w_cmdValid;
    logic                  w_cmdFire;
    logic                  w_rspFire;
    logic                  w_flushAck;
    logic                  w_fifoNonEmpty;
    logic                  w_bypass;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_outAdv;
    logic [3:0]            w_unused;

    // Credits count both in-flight and buffered entries so responses always fit.
    assign w_credit       = ({1'b0, r_outsCnt} + {1'b0, r_occ}) < DEPTH_EXT;
    assign w_cmdValid     = ~rst & (r_cmdPending | (~io.halt_req & ~io.flush_req & w_credit));
    assign w_cmdFire      = w_cmdValid & io.icb_cmd_ready;
    assign w_rspFire      = io.icb_rsp_valid;
    assign w_flushAck     = ~rst & io.flush_req & (~w_cmdValid | io.icb_cmd_ready);
    assign w_fifoNonEmpty = (r_occ != '0);

`ifdef E203_IFU_PFQ_BYPASS_EN
    assign w_bypass  = ~rst & ~w_fifoNonEmpty & (r_dropCnt == '0) & ~w_flushAck
                     & io.o_ready & w_rspFire;
    assign io.o_valid = w_fifoNonEmpty | w_bypass;
    assign io.o_instr = w_bypass ? io.icb_rsp_rdata : r_instrMem[r_rdPtr];
    assign io.o_err   = w_bypass ? io.icb_rsp_err   : r_errMem[r_rdPtr];
`else
    assign w_bypass   = 1'b0;
    assign io.o_valid = w_fifoNonEmpty;
    assign io.o_instr = r_instrMem[r_rdPtr];
    assign io.o_err   = r_errMem[r_rdPtr];
`endif

    // A response in the ack cycle is stale by definition, whatever the drop count says.
    assign w_drop   = w_flushAck | (r_dropCnt != '0);
    assign w_push   = w_rspFire & ~w_drop & ~w_bypass;
    assign w_pop    = w_fifoNonEmpty & io.o_ready & ~w_flushAck;
    assign w_outAdv = w_pop | w_bypass;
    assign w_unused = {io.pc_rtvec[1:0], io.flush_pc[1:0]};

    assign io.icb_cmd_valid = w_cmdValid;
    assign io.icb_cmd_addr  = r_fetchPc;
    assign io.icb_rsp_ready = 1'b1;
    assign io.o_pc          = r_outPc;
    assign io.flush_ack     = w_flushAck;
    assign io.halt_ack      = ~rst & io.halt_req & ~w_cmdValid & (r_outsCnt == '0);
    assign io.occupancy     = r_occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPc    <= {io.pc_rtvec[PC_SIZE-1:2], 2'b00};
            r_outPc      <= {io.pc_rtvec[PC_SIZE-1:2], 2'b00};
            r_cmdPending <= 1'b0;
            r_outsCnt    <= '0;
            r_dropCnt    <= '0;
            r_occ        <= '0;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
        end else begin
            r_cmdPending <= w_cmdValid & ~io.icb_cmd_ready;
            r_outsCnt    <= r_outsCnt + CNT_W'(w_cmdFire) - CNT_W'(w_rspFire);
            if (w_flushAck) begin
                r_fetchPc <= {io.flush_pc[PC_SIZE-1:2], 2'b00};
                r_outPc   <= {io.flush_pc[PC_SIZE-1:2], 2'b00};
                r_dropCnt <= r_outsCnt + CNT_W'(w_cmdFire) - CNT_W'(w_rspFire);
                r_occ     <= '0;
                r_wrPtr   <= '0;
                r_rdPtr   <= '0;
            end else begin
                if (w_cmdFire)
                    r_fetchPc <= r_fetchPc + PC_STEP;
                if (w_outAdv)
                    r_outPc <= r_outPc + PC_STEP;
                if (w_rspFire && r_dropCnt != '0)
                    r_dropCnt <= r_dropCnt - CNT_W'(1);
                if (w_push)
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                if (w_pop)
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                r_occ <= r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= io.icb_rsp_rdata;
            r_errMem[r_wrPtr]   <= io.icb_rsp_err;
        end
    end

    // The credit rule makes a push into a full queue impossible.
    always @(posedge clk) begin
        if (!rst)
            assert (!(w_push && !w_pop && r_occ == DEPTH_CNT));
    end
endmodule

// File: doc/e203_ifu_pfq.md
Name: e203_ifu_pfq

Overview:
Parametrised instruction prefetch queue for the next-generation IFU. It sits between the fetch-control logic and the ICB fetch port. It issues sequential word fetches ahead of consumption, keeps up to PF_DEPTH instructions in flight or buffered, and tracks the PC of each delivered instruction. Its main addition over the current IFU is flush handling with drop-counting of stale responses, plus halt handshaking on an empty bus.

Parameters:
PC_SIZE, 32, width of PC and fetch address
INSTR_SIZE, 32, width of fetched instruction word
PF_DEPTH, 4, max (outstanding + buffered) fetches; power of two, range 2..16
CNT_W, clog2(PF_DEPTH+1), width of occupancy/outstanding counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
pc_rtvec  in  PC_SIZE  reset fetch PC, sampled while rst=1
icb_cmd_valid  out  1  fetch command valid
icb_cmd_ready  in  1  fetch command accepted
icb_cmd_addr  out  PC_SIZE  word-aligned fetch address
icb_rsp_valid  in  1  fetch response valid
icb_rsp_ready  out  1  always 1 (space reserved at issue)
icb_rsp_err  in  1  bus error on response
icb_rsp_rdata  in  INSTR_SIZE  instruction word
o_valid  out  1  instruction available
o_ready  in  1  consumer accepts
o_instr  out  INSTR_SIZE  head instruction
o_pc  out  PC_SIZE  PC of head instruction
o_err  out  1  head fetch bus error
flush_req  in  1  redirect request
flush_pc  in  PC_SIZE  redirect target
flush_ack  out  1  redirect accepted this cycle
halt_req  in  1  stop fetching
halt_ack  out  1  no fetch pending or in flight
occupancy  out  CNT_W  buffered entry count (debug)

Behaviour:
- Clock and reset: one clock clk; synchronous active-high reset rst. Reset values: fetch_pc=out_pc={pc_rtvec[PC_SIZE-1:2],2'b00}; FIFO empty; outs_cnt=drop_cnt=0; icb_cmd_valid=0; o_valid=0; flush_ack=0; halt_ack=0; occupancy=0. A reset mid-operation discards all state; the bus is reset concurrently, so no stale responses follow.
- Issue: icb_cmd_valid = ~halt_req & ~flush_req & (outs_cnt+occupancy < PF_DEPTH), or 1 if a command is already pending. Once asserted, valid and addr hold until accepted (no retraction). icb_cmd_addr=fetch_pc. On cmd fire: fetch_pc += 4, modulo 2^PC_SIZE (wraps), and outs_cnt++.
- Response: rsp fire decrements outs_cnt. If drop_cnt>0, the response is discarded and drop_cnt--. Otherwise {rdata,err} is pushed into the FIFO. The credit rule guarantees no overflow, so overflow is an assertion failure.
- Output: o_valid = FIFO non-empty. o_pc = out_pc. On pop, out_pc += 4 (wraps). Push and pop in the same cycle leave occupancy unchanged.
- Latency: response at cycle N gives o_valid at N+1. Command-to-output minimum is bus latency + 1.
- Flush: flush_ack = flush_req & (~icb_cmd_valid | icb_cmd_ready). On ack:
  - FIFO cleared next cycle; any same-cycle push and pop are ignored.
  - fetch_pc = out_pc = {flush_pc[PC_SIZE-1:2],2'b00}.
  - drop_cnt = outs_cnt + cmd_fire - rsp_fire (all in-flight fetches, including one accepted this cycle).
  - A response arriving in the ack cycle is dropped regardless of drop_cnt.
- Back-to-back flushes each reload drop_cnt by the same rule. Issuing resumes the cycle after ack, while drops drain concurrently.
- Halt: while halt_req=1 no new command is raised. halt_ack = halt_req & ~icb_cmd_valid & (outs_cnt==0). The FIFO keeps draining to the consumer during halt.
- Simultaneous flush_req and halt_req: flush is serviced; halt_ack waits for the flushed fetches to drain.

Optional Feature:
E203_IFU_PFQ_BYPASS_EN:
- Defined: when the FIFO is empty, drop_cnt=0, no flush is acked, and o_ready=1, a response passes straight to the output in the same cycle (o_valid=icb_rsp_valid, o_instr=rdata, o_err=err). The FIFO is not written, out_pc increments, and latency is 0 cycles.
- Not defined: every response goes through the FIFO, with 1-cycle latency.

Test Plan:
- Reset with pc_rtvec=0x8000_0000, bus always ready with 1-cycle latency, o_ready=1 -> commands to 0x80000000, 0x80000004, ...; o_pc sequence matches; steady-state one instruction per cycle; occupancy ≤4.
- o_ready=0 with PF_DEPTH=4 -> exactly 4 commands issued, then icb_cmd_valid=0 until a pop; occupancy=4.
- Two fetches in flight, flush_pc=0x100 -> flush_ack same cycle; both stale responses dropped; next o_pc=0x100, with first command 0x100 issued the cycle after ack.
- Flush while cmd_valid=1 and cmd_ready=0 -> flush_ack=0 until the command is accepted; that command's response is dropped.
- halt_req with 3 outstanding -> no new commands; halt_ack rises the cycle outs_cnt reaches 0; buffered instructions still delivered.
- fetch_pc=0xFFFF_FFFC with PC_SIZE=32 -> next address 0x0000_0000; response with err=1 -> o_err=1 at matching o_pc.
